// File: rtl/xadc_pkg.sv
// xadc_pkg: definitions shared by the XADC DRP front end.
//   drp_state_t  : reader FSM states (IDLE / REQ / WAIT)
//   DRP_DATA_W   : DRP data bus width (16)
//   DRP_ADDR_W   : DRP address bus width (7)
//   XADC_ADDR_*  : status register addresses of the XADC primitive
package xadc_pkg;

    localparam int DRP_DATA_W = 16;
    localparam int DRP_ADDR_W = 7;

    localparam logic [DRP_ADDR_W-1:0] XADC_ADDR_TEMP   = 7'h00;
    localparam logic [DRP_ADDR_W-1:0] XADC_ADDR_VCCINT = 7'h01;
    localparam logic [DRP_ADDR_W-1:0] XADC_ADDR_VCCAUX = 7'h02;
    localparam logic [DRP_ADDR_W-1:0] XADC_ADDR_VPVN   = 7'h03;
    localparam logic [DRP_ADDR_W-1:0] XADC_ADDR_VREFP  = 7'h04;
    localparam logic [DRP_ADDR_W-1:0] XADC_ADDR_VREFN  = 7'h05;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } drp_state_t;

endpackage

// File: rtl/xadc_drp_reader.sv
// xadc_drp_reader: one DRP read of a fixed XADC status register per
// end-of-conversion strobe. The top N bits of the returned word are
// presented on data with a one-cycle data_valid pulse.
//
// Optional feature macro: XADC_DRP_TIMEOUT_EN
//   defined   -> a WAIT-cycle counter aborts reads that get no drdy within
//                TIMEOUT_CYCLES cycles and raises sticky timeout_err
//   undefined -> WAIT holds until drdy, timeout_err is tied low
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   eoc             XADC end-of-conversion pulse
//   drdy, do_in     DRP read handshake / data from the XADC
//   den, dwe        DRP enable pulse / write enable (always 0)
//   daddr, di       DRP address (CHANNEL_ADDR) / write data (always 0)
//   data            last captured sample, held between reads
//   data_valid      one-cycle pulse when data updates
//   overrun         sticky: a conversion was dropped
//   timeout_err     sticky: a DRP read was aborted
//   clear_err       clears both sticky flags (a same-cycle set wins)
module xadc_drp_reader
    import xadc_pkg::*;
#(
    parameter int                    N              = 12,
    parameter logic [DRP_ADDR_W-1:0] CHANNEL_ADDR   = XADC_ADDR_VPVN,
    parameter int                    TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  eoc,
    input  logic                  drdy,
    input  logic [DRP_DATA_W-1:0] do_in,
    output logic                  den,
    output logic                  dwe,
    output logic [DRP_ADDR_W-1:0] daddr,
    output logic [DRP_DATA_W-1:0] di,
    output logic [N-1:0]          data,
    output logic                  data_valid,
    output logic                  overrun,
    output logic                  timeout_err,
    input  logic                  clear_err
);

    // Elaboration trap: an out-of-range parameter instantiates a module
    // that does not exist, so the build stops instead of misbehaving.
    if (N < 1 || N > DRP_DATA_W || TIMEOUT_CYCLES < 2) begin : g_param_check
        xadc_drp_reader_bad_parameter u_bad_param ();
    end

    drp_state_t state_q, state_d;
    logic       pending_q, pending_d;
    logic       busy, complete, abort;
    logic       den_d, overrun_set;

    // Low bits of the DRP word below the sample are intentionally dropped.
    logic unused_do_in;
    assign unused_do_in = ^do_in;

    assign dwe   = 1'b0;
    assign daddr = CHANNEL_ADDR;
    assign di    = '0;

    assign busy = (state_q != ST_IDLE);
    // drdy in REQ finishes the read exactly like drdy in WAIT.
    assign complete = busy && drdy;

`ifdef XADC_DRP_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Clearing during REQ is the same as clearing on entry to WAIT, and it
    // also restarts the count for back-to-back reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state_q == ST_REQ) begin
            tmo_cnt <= '0;
        end else if (state_q == ST_WAIT && !drdy) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th WAIT cycle without drdy.
    assign abort = (state_q == ST_WAIT) && !drdy &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign abort = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            ST_IDLE: begin
                if (eoc) state_d = ST_REQ;
            end
            ST_REQ, ST_WAIT: begin
                if (complete) begin
                    // An eoc in the completing cycle is still "busy": it
                    // becomes the next read, or is queued behind the one
                    // already pending.
                    state_d   = (pending_q || eoc) ? ST_REQ : ST_IDLE;
                    pending_d = pending_q && eoc;
                end else if (abort) begin
                    state_d   = ST_IDLE;
                    pending_d = 1'b0;
                end else begin
                    state_d = ST_WAIT;
                    if (eoc) pending_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    // Output decode; registered below so no input reaches an output
    // combinationally.
    always_comb begin
        den_d = (state_d == ST_REQ);
        // A pending slot consumed this cycle frees room for the new eoc.
        overrun_set = busy && eoc && pending_q && !complete;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            den        <= 1'b0;
            data_valid <= 1'b0;
            data       <= '0;
            overrun    <= 1'b0;
        end else begin
            den        <= den_d;
            data_valid <= complete;
            if (complete) data <= do_in[DRP_DATA_W-1 -: N];
            overrun    <= overrun_set | (overrun & ~clear_err);
        end
    end

`ifdef XADC_DRP_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) timeout_err <= 1'b0;
        else       timeout_err <= abort | (timeout_err & ~clear_err);
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule
